// File: rtl/gas_scan_controller.sv
// -----------------------------------------------------------------------------
// gas_scan_controller
//
// Shares one gas detector between NCH room sensor lines. For each channel in
// turn the detector is held in reset, fed WIN bits of that channel's serial
// data, and then its 3-bit gas flags are sampled. The flags are accumulated
// per channel (sticky until clr). Any non-zero sample is reported to the
// alarm unit before the scan moves on.
//
// Optional feature (compile-time macro GAS_SCAN_MASK_EN):
//   Adds input ch_mask. Masked channels are skipped, searching cyclically.
//   With every channel masked the block parks in IDLE.
//
// Ports:
//   clk          clock, rising edge
//   arst         asynchronous reset, active-high
//   enable       scanning enabled (looked at only in IDLE and NEXT)
//   ch_din       serial data, one bit per channel
//   ch_mask      (GAS_SCAN_MASK_EN only) 1 = skip that channel
//   det_rst      registered reset to the shared detector, active-high
//   det_din      serial data to the detector (selected channel during RUN)
//   det_flags    detector output: [2] dioxide, [1] monoxide, [0] methane
//   ch_flags     sticky flags, channel i at [3i+2:3i]
//   clr          clear all ch_flags on the next edge
//   alarm_req    detection report pending
//   alarm_ack    alarm unit accepts the report
//   alarm_ch     channel of the report
//   alarm_gas    flags of the report
//   busy         state is not IDLE
//   dbg_state_o  current FSM state (debug)
//   dbg_cur_o    current channel index (debug)
//
// Handshake: alarm_req rises together with alarm_ch/alarm_gas when a
// detection is sampled and all three stay stable until alarm_ack is seen
// high on a rising edge while the report is pending; that edge drops
// alarm_req. alarm_ack at any other time has no effect.
// -----------------------------------------------------------------------------
module gas_scan_controller #(
  parameter int NCH     = 4,
  parameter int CHW     = 2,
  parameter int WIN     = 64,
  parameter int RST_CYC = 2
) (
  input  logic               clk,
  input  logic               arst,
  input  logic               enable,
  input  logic [NCH-1:0]     ch_din,
`ifdef GAS_SCAN_MASK_EN
  input  logic [NCH-1:0]     ch_mask,
`endif
  output logic               det_rst,
  output logic               det_din,
  input  logic [2:0]         det_flags,
  output logic [3*NCH-1:0]   ch_flags,
  input  logic               clr,
  output logic               alarm_req,
  input  logic               alarm_ack,
  output logic [CHW-1:0]     alarm_ch,
  output logic [2:0]         alarm_gas,
  output logic               busy,
  output logic [2:0]         dbg_state_o,
  output logic [CHW-1:0]     dbg_cur_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RESET  = 3'd1,
    S_RUN    = 3'd2,
    S_SAMPLE = 3'd3,
    S_REPORT = 3'd4,
    S_NEXT   = 3'd5
  } state_t;

  // One counter times both the reset pulse and the RUN window.
  localparam int CNT_MAX = (WIN > RST_CYC) ? WIN : RST_CYC;
  localparam int CNTW    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  state_t             state_q, state_d;
  logic [CHW-1:0]     cur_q, cur_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic [3*NCH-1:0]   flags_q, flags_d;
  logic               req_q, req_d;
  logic [CHW-1:0]     ach_q, ach_d;
  logic [2:0]         agas_q, agas_d;
  logic               det_rst_q, det_rst_d;

  // Channel to start on when leaving IDLE, channel to move to from NEXT,
  // and whether there is anything to scan at all.
  logic [CHW-1:0]     cur_start;
  logic [CHW-1:0]     cur_adv;
  logic               scan_ok;

  function automatic logic [CHW-1:0] wrap_inc(input logic [CHW-1:0] c);
    if (c == CHW'(NCH - 1)) return '0;
    return c + 1'b1;
  endfunction

`ifdef GAS_SCAN_MASK_EN
  // First unmasked channel at or after 'start', cyclically. Returns 'start'
  // when everything is masked; callers gate on scan_ok in that case.
  function automatic logic [CHW-1:0] first_unmasked(input logic [CHW-1:0] start,
                                                    input logic [NCH-1:0] m);
    logic [CHW-1:0] p;
    logic [CHW-1:0] r;
    logic           found;
    p     = start;
    r     = start;
    found = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (!found && !m[p]) begin
        r     = p;
        found = 1'b1;
      end
      p = wrap_inc(p);
    end
    return r;
  endfunction

  always_comb begin
    scan_ok   = |(~ch_mask);
    cur_start = first_unmasked(cur_q, ch_mask);
    cur_adv   = first_unmasked(wrap_inc(cur_q), ch_mask);
  end
`else
  always_comb begin
    scan_ok   = 1'b1;
    cur_start = cur_q;
    cur_adv   = wrap_inc(cur_q);
  end
`endif

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    // clr wipes history; a coinciding SAMPLE then ORs into the cleared value.
    flags_d = clr ? '0 : flags_q;
    req_d   = req_q;
    ach_d   = ach_q;
    agas_d  = agas_q;

    case (state_q)
      S_IDLE: begin
        if (enable && scan_ok) begin
          state_d = S_RESET;
          cur_d   = cur_start;
          cnt_d   = '0;
        end
      end
      S_RESET: begin
        if (cnt_q == CNTW'(RST_CYC - 1)) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        if (cnt_q == CNTW'(WIN - 1)) begin
          state_d = S_SAMPLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SAMPLE: begin
        flags_d[3*cur_q +: 3] = flags_d[3*cur_q +: 3] | det_flags;
        if (det_flags != 3'b000) begin
          req_d   = 1'b1;
          ach_d   = cur_q;
          agas_d  = det_flags;
          state_d = S_REPORT;
        end else begin
          state_d = S_NEXT;
        end
      end
      S_REPORT: begin
        if (alarm_ack) begin
          req_d   = 1'b0;
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        cur_d   = cur_adv;
        cnt_d   = '0;
        state_d = (enable && scan_ok) ? S_RESET : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // det_rst is registered, so it is decoded from the state being entered.
    det_rst_d = (state_d == S_IDLE) || (state_d == S_RESET) ||
                (state_d == S_REPORT);
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q   <= S_IDLE;
      cur_q     <= '0;
      cnt_q     <= '0;
      flags_q   <= '0;
      req_q     <= 1'b0;
      ach_q     <= '0;
      agas_q    <= 3'b000;
      det_rst_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      cnt_q     <= cnt_d;
      flags_q   <= flags_d;
      req_q     <= req_d;
      ach_q     <= ach_d;
      agas_q    <= agas_d;
      det_rst_q <= det_rst_d;
    end
  end

  // Data path to the detector is a plain mux so the RUN bit seen on each
  // edge is the channel bit present in that same cycle.
  assign det_din     = (state_q == S_RUN) ? ch_din[cur_q] : 1'b0;
  assign det_rst     = det_rst_q;
  assign ch_flags    = flags_q;
  assign alarm_req   = req_q;
  assign alarm_ch    = ach_q;
  assign alarm_gas   = agas_q;
  assign busy        = (state_q != S_IDLE);
  assign dbg_state_o = state_q;
  assign dbg_cur_o   = cur_q;

endmodule

// File: tb/tb_gas_scan_controller.sv
// -----------------------------------------------------------------------------
// tb_gas_scan_controller
//
// Drives gas_scan_controller (NCH=4, WIN=16, RST_CYC=2) through directed and
// randomized channel visits. The reference model works per channel visit:
// it knows the expected phase lengths, which channel should be scanned next,
// the accumulated sticky flags and the last report. Inputs are driven and
// outputs observed on the falling edge.
// -----------------------------------------------------------------------------
module tb_gas_scan_controller;

  localparam int NCH     = 4;
  localparam int CHW     = 2;
  localparam int WIN     = 16;
  localparam int RST_CYC = 2;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic arst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic               enable    = 1'b0;
  logic [NCH-1:0]     ch_din    = '0;
  logic [NCH-1:0]     mask_v    = '0;
  logic [2:0]         det_flags = 3'b000;
  logic               clr       = 1'b0;
  logic               alarm_ack = 1'b0;
  logic               det_rst;
  logic               det_din;
  logic [3*NCH-1:0]   ch_flags;
  logic               alarm_req;
  logic [CHW-1:0]     alarm_ch;
  logic [2:0]         alarm_gas;
  logic               busy;
  logic [2:0]         dbg_state;
  logic [CHW-1:0]     dbg_cur;

  gas_scan_controller #(
    .NCH(NCH), .CHW(CHW), .WIN(WIN), .RST_CYC(RST_CYC)
  ) dut (
    .clk(clk),
    .arst(arst),
    .enable(enable),
    .ch_din(ch_din),
`ifdef GAS_SCAN_MASK_EN
    .ch_mask(mask_v),
`endif
    .det_rst(det_rst),
    .det_din(det_din),
    .det_flags(det_flags),
    .ch_flags(ch_flags),
    .clr(clr),
    .alarm_req(alarm_req),
    .alarm_ack(alarm_ack),
    .alarm_ch(alarm_ch),
    .alarm_gas(alarm_gas),
    .busy(busy),
    .dbg_state_o(dbg_state),
    .dbg_cur_o(dbg_cur)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  logic [0:0]         exp_q[$];      // bits the detector should receive
  int                 exp_cur    = 0;
  logic [3*NCH-1:0]   exp_flags  = '0;
  logic [CHW-1:0]     exp_al_ch  = '0;
  logic [2:0]         exp_al_gas = 3'b000;
  logic [2:0]         idle_code  = 3'b000;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Next channel to scan at or after 'start', skipping masked ones.
  function automatic int first_open(input int start);
    for (int k = 0; k < NCH; k++) begin
      if (!mask_v[(start + k) % NCH]) return (start + k) % NCH;
    end
    return start % NCH;
  endfunction

  task automatic model_reset();
    exp_cur    = 0;
    exp_flags  = '0;
    exp_al_ch  = '0;
    exp_al_gas = 3'b000;
  endtask

  // Call from an IDLE cycle: the next edge starts a channel.
  task automatic start_scan();
    enable  = 1'b1;
    exp_cur = first_open(exp_cur);
  endtask

  task automatic idle_cycles(input int n);
    int bad_cyc;
    bad_cyc = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      alarm_ack = 1'($urandom_range(1, 0));
      ch_din    = NCH'($urandom);
      #1;
      if (busy || !det_rst || det_din || alarm_req || dbg_state !== idle_code) bad_cyc++;
    end
    alarm_ack = 1'b0;
    check("idle_hold", bad_cyc, 0);
  endtask

  // One full channel visit, starting with the edge that enters RESET.
  // clr_mode: 0 none, 1 clr in the SAMPLE cycle, 2 clr mid-RUN.
  task automatic visit(input logic [2:0] gas, input int ack_wait, input logic en_after,
                       input int clr_mode, input logic arst_rep);
    int   ch;
    int   rst_hi;
    int   run_bad;
    int   rep_bad;
    logic exp_bit;
    ch      = exp_cur;
    rst_hi  = 0;
    run_bad = 0;
    rep_bad = 0;

    // RESET phase
    for (int i = 0; i < RST_CYC; i++) begin
      @(negedge clk);
      #1;
      if (det_rst) rst_hi++;
      if (alarm_req || det_din) run_bad++;
      if (i == 0) begin
        check("start_cur", dbg_cur, ch);
        check("start_busy", busy, 1);
      end
      det_flags = 3'($urandom_range(7, 1));
      enable    = 1'($urandom_range(1, 0));
      alarm_ack = 1'($urandom_range(1, 0));
      ch_din    = NCH'($urandom);
    end

    // RUN phase: detector must see ch_din[ch] in every cycle
    for (int i = 0; i < WIN; i++) begin
      @(negedge clk);
      ch_din    = NCH'($urandom);
      alarm_ack = 1'($urandom_range(1, 0));
      enable    = 1'($urandom_range(1, 0));
      det_flags = 3'($urandom_range(7, 1));
      clr       = (clr_mode == 2) && (i == WIN / 2);
      if (clr) exp_flags = '0;
      exp_q.push_back(ch_din[ch]);
      #1;
      if (det_rst) rst_hi++;
      if (alarm_req) run_bad++;
      exp_bit = exp_q.pop_front();
      if (det_din !== exp_bit) run_bad++;
    end

    // SAMPLE cycle: the detector result is presented only here
    @(negedge clk);
    ch_din    = '1;
    det_flags = gas;
    clr       = (clr_mode == 1);
    enable    = 1'($urandom_range(1, 0));
    alarm_ack = (gas != 3'b000) ? (ack_wait == 0) : 1'($urandom_range(1, 0));
    #1;
    if (det_rst) rst_hi++;
    if (det_din || alarm_req) run_bad++;
    if (clr) exp_flags = '0;
    exp_flags[3*ch +: 3] = exp_flags[3*ch +: 3] | gas;
    if (gas != 3'b000) begin
      exp_al_ch  = CHW'(ch);
      exp_al_gas = gas;
    end

    // REPORT phase
    if (gas != 3'b000) begin
      for (int r = 0; r <= ack_wait; r++) begin
        @(negedge clk);
        clr       = 1'b0;
        det_flags = 3'($urandom_range(7, 0));
        ch_din    = NCH'($urandom);
        #1;
        if (r == 0) begin
          check("req_rise", alarm_req, 1);
          check("rep_ch", alarm_ch, ch);
          check("rep_gas", alarm_gas, gas);
          check("rep_flags", ch_flags, exp_flags);
        end else if (alarm_req !== 1'b1 || alarm_ch !== exp_al_ch || alarm_gas !== exp_al_gas) begin
          rep_bad++;
        end
        if (!det_rst || det_din || !busy) rep_bad++;
        if (arst_rep && r == 1) begin
          arst      = 1'b1;
          enable    = 1'b0;
          alarm_ack = 1'b0;
          #1;
          check("arst_req", alarm_req, 0);
          check("arst_busy", busy, 0);
          check("arst_det_rst", det_rst, 1);
          check("arst_flags", ch_flags, 0);
          check("arst_al_ch", alarm_ch, 0);
          check("arst_al_gas", alarm_gas, 0);
          check("arst_cur", dbg_cur, 0);
          @(negedge clk);
          arst = 1'b0;
          model_reset();
          return;
        end
        alarm_ack = (r == ack_wait);
      end
      check("rep_stable", rep_bad, 0);
    end

    // NEXT cycle
    @(negedge clk);
    alarm_ack = 1'($urandom_range(1, 0));
    det_flags = 3'($urandom_range(7, 0));
    clr       = 1'b0;
    #1;
    if (det_rst) rst_hi++;
    check("rst_cycles", rst_hi, RST_CYC);
    check("run_stream", run_bad, 0);
    check("next_req", alarm_req, 0);
    check("next_busy", busy, 1);
    check("flags", ch_flags, exp_flags);
    check("al_ch", alarm_ch, exp_al_ch);
    check("al_gas", alarm_gas, exp_al_gas);
    enable  = en_after;
    exp_cur = first_open(ch + 1);
    if (!en_after) begin
      @(negedge clk);
      alarm_ack = 1'b0;
      #1;
      check("idle_busy", busy, 0);
      check("idle_det_rst", det_rst, 1);
      check("idle_cur", dbg_cur, exp_cur);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [2:0] g;
    int         aw;
    int         cm;
    logic       en;

    repeat (3) @(negedge clk);
    ch_din = '1;
    #1;
    check("rst_det_rst", det_rst, 1);
    check("rst_det_din", det_din, 0);
    check("rst_flags", ch_flags, 0);
    check("rst_req", alarm_req, 0);
    check("rst_al_ch", alarm_ch, 0);
    check("rst_al_gas", alarm_gas, 0);
    check("rst_busy", busy, 0);
    check("rst_cur", dbg_cur, 0);
    idle_code = dbg_state;
    @(negedge clk);
    arst = 1'b0;
    idle_cycles(3);

    // Quiet scan: 0,1,2,3,0, no reports
    start_scan();
    for (int k = 0; k < 5; k++) visit(3'b000, 0, 1'b1, 0, 1'b0);

    // Detections: minimum handshake on ch1, held ack on ch2, clr at SAMPLE on ch3
    visit(3'b010, 0, 1'b1, 0, 1'b0);
    visit(3'b100, 5, 1'b1, 0, 1'b0);
    check("ch2_flags", ch_flags[8:6], 3'b100);
    visit(3'b001, 0, 1'b1, 1, 1'b0);
    check("clr_result", ch_flags, 12'b001_000_000_000);

    // enable dropped during ch0: finish it, then park with cur=1
    visit(3'b000, 0, 1'b0, 0, 1'b0);
    idle_cycles(4);

    // Randomized visits
    start_scan();
    for (int k = 0; k < 14; k++) begin
      g  = ($urandom_range(1, 0) == 1) ? 3'($urandom_range(7, 1)) : 3'b000;
      aw = $urandom_range(4, 0);
      cm = $urandom_range(5, 0);
      if (cm > 2) cm = 0;
      en = (k == 13) ? 1'b0 : ($urandom_range(4, 0) != 0);
      visit(g, aw, en, cm, 1'b0);
      if (!en && k != 13) start_scan();
    end

    // Asynchronous reset in the middle of a report
    start_scan();
    visit(3'b011, 4, 1'b1, 0, 1'b1);
    idle_cycles(2);
    start_scan();
    visit(3'b000, 0, 1'b0, 0, 1'b0);

`ifdef GAS_SCAN_MASK_EN
    @(negedge clk);
    arst = 1'b1;
    @(negedge clk);
    arst = 1'b0;
    model_reset();
    mask_v = 4'b1010;
    start_scan();
    for (int k = 0; k < 4; k++) visit(3'b000, 0, (k != 3), 0, 1'b0);
    mask_v = 4'b1111;
    enable = 1'b1;
    idle_cycles(8);
    enable = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gas_scan_controller.md
# gas_scan_controller

Time-multiplexes one shared gas detector across NCH room sensor lines. For each channel it resets the detector, streams that channel's serial data into it for a fixed window, samples the detector's 3-bit gas flags and accumulates them per channel. On any detection it reports to the house alarm unit over a req/ack handshake. It sits between the room sensor inputs and the single detector instance, and feeds the alarm/display logic.

## Interface
- NCH, 4: number of sensor channels, 2..16
- CHW, 2: channel index width, ≥ clog2(NCH)
- WIN, 64: RUN window length in clk cycles, ≥ 8
- RST_CYC, 2: detector reset pulse length in cycles, ≥ 1

- clk  in  1  clock, posedge
- arst  in  1  reset, asynchronous, active-high
- enable  in  1  scanning enabled
- ch_din  in  NCH  serial data, one bit per channel
- det_rst  out  1  reset to shared detector, registered, active-high
- det_din  out  1  serial data to shared detector
- det_flags  in  3  detector output: [2] dioxide, [1] monoxide, [0] methane
- ch_flags  out  3*NCH  sticky flags; channel i at [3i+2:3i]
- clr  in  1  clear all ch_flags
- alarm_req  out  1  detection report pending
- alarm_ack  in  1  alarm unit accepts report
- alarm_ch  out  CHW  channel of pending report
- alarm_gas  out  3  flags of pending report
- busy  out  1  state ≠ IDLE

## Operation
- Reset values:
  - state IDLE, cur = 0, det_rst = 1, det_din = 0.
  - ch_flags = 0, alarm_req = 0, alarm_ch = 0, alarm_gas = 0, busy = 0.
  - All counters 0.
- States:
  - IDLE: det_rst = 1. Go to RESET when enable = 1.
  - RESET: det_rst = 1 for RST_CYC cycles, then RUN.
  - RUN: det_rst = 0, det_din = ch_din[cur] (combinational mux) for WIN cycles, then SAMPLE.
  - SAMPLE: det_din = 0, det_rst = 0.
    - Capture f = det_flags and set ch_flags[cur] |= f.
    - If f ≠ 0: load alarm_ch = cur and alarm_gas = f, set alarm_req = 1, go to REPORT.
    - Otherwise go to NEXT.
  - REPORT: det_rst = 1. Hold alarm_req, alarm_ch and alarm_gas stable until alarm_ack = 1 is sampled. In that cycle clear alarm_req and go to NEXT.
  - NEXT:
    - cur = cur + 1, wrapping from NCH-1 to 0.
    - If enable = 1 go to RESET; otherwise go to IDLE.
- det_din = 0 in every state except RUN.
- enable is sampled only in IDLE and NEXT. Deasserting it mid-channel completes that channel, including any REPORT.
- alarm_ack outside REPORT is ignored.
- clr clears ch_flags on the next edge.
  - If clr coincides with SAMPLE, the result is ch_flags = 0 except channel cur, which becomes f.
  - clr does not affect alarm_req, alarm_ch or alarm_gas.
- arst mid-operation: returns to the reset values immediately. A pending report is dropped. det_rst asserts immediately.

## Timing
- Per channel with no detection: RST_CYC + WIN + 2 cycles (RESET, RUN, SAMPLE, NEXT).
- Per channel with detection: add 1 + (cycles until ack) for REPORT.
- The first RUN data bit is the ch_din value sampled by the detector on the first RUN edge. The detector sees exactly WIN bits.
- det_flags is sampled on the SAMPLE edge, which is one cycle after the last RUN bit.
- alarm_req rises on the edge that leaves SAMPLE. It falls on the edge where alarm_ack = 1 is seen in REPORT.
- Minimum handshake: ack held high while req rises → report lasts 1 cycle.
- Full scan period with no detections: NCH·(RST_CYC + WIN + 2).

## Configuration
- GAS_SCAN_MASK_EN
- Defined:
  - Adds input ch_mask [NCH-1:0]. In NEXT (and when leaving IDLE), cur advances to the next unmasked channel, searching cyclically.
  - If all channels are masked, the block stays in, or goes to, IDLE with det_rst = 1.
  - A channel masked mid-window completes normally.
- Undefined: the port is absent and all channels are scanned in order.

## Test plan
- NCH=4, WIN=16, detector model returns 0 → cur visits 0,1,2,3,0 with each channel taking 20 cycles; alarm_req never asserts and det_rst is high exactly 2 cycles per channel.
- Model returns 3'b100 on channel 2 → alarm_req=1, alarm_ch=2, alarm_gas=3'b100, ch_flags[8:6]=3'b100. Hold ack low 5 cycles and check outputs stay stable; assert ack and check req drops, then channel 3 starts.
- Channel 1 flags 3'b010 stored; clr asserted in the SAMPLE cycle of channel 3 with f=3'b001 → ch_flags = 0 except [11:9] = 3'b001.
- enable dropped mid-RUN on channel 0 → channel 0 completes, then NEXT → IDLE with cur=1, det_rst=1 and busy=0.
- arst pulsed during REPORT → alarm_req=0, state IDLE, ch_flags=0 and det_rst=1 within the same cycle.
- With GAS_SCAN_MASK_EN and ch_mask=4'b1010 → scan order 0,2,0,2. With ch_mask=4'b1111 → the block stays IDLE.
